segment_decoder: RTL

SEGMENT_DECODER -- requirements
Module: segment_decoder

---
 rtl/segment_decoder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/segment_decoder.sv
// Recovers a 4-digit hex value by sniffing a multiplexed 7-segment display bus.
// Optional per-digit decimal point capture is enabled with SEG_DEC_DP_EN.
module segment_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk100Mhz,
  input  logic        rst_n,
  input  logic [3:0]  anodes,
  input  logic [7:1]  cathodes,
  input  logic        dp_n,
  output logic [15:0] value,
  output logic [3:0]  dp_out,
  output logic        valid,
  output logic        err,
  output logic        stale
);

  // state  | meaning
  // IDLE   | waiting for exactly one active anode
  // SETTLE | counting stable cycles of the snapshotted digit
  // HOLD   | digit accepted, waiting for the anodes to move on
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  state_t          state, state_nxt;
  logic [3:0]      an_meta, an_s, snap_an;
  logic [7:1]      cat_meta, cat_s, snap_cat;
  logic [SW-1:0]   cnt;
  logic [TW-1:0]   to_cnt;
  logic [15:0]     shadow;
  logic [3:0]      mask;
  logic            load_snap, cnt_inc, cnt_clr, accept, same_snap;
  logic [4:0]      glyph_dec;
  logic [1:0]      slot;

  function automatic logic one_low(input logic [3:0] a);
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] slot_of(input logic [3:0] a);
    case (a)
      4'b1101: slot_of = 2'd1;
      4'b1011: slot_of = 2'd2;
      4'b0111: slot_of = 2'd3;
      default: slot_of = 2'd0;
    endcase
  endfunction

  // Input is lit segments a..g (MSB = a); result is {recognised, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b1001110: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1001111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      an_meta  <= '1;
      an_s     <= '1;
      cat_meta <= '1;
      cat_s    <= '1;
    end else begin
      an_meta  <= anodes;
      an_s     <= an_meta;
      cat_meta <= cathodes;
      cat_s    <= cat_meta;
    end
  end

`ifdef SEG_DEC_DP_EN
  logic       dp_meta, dp_s, snap_dp;
  logic [3:0] shadow_dp;

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      dp_meta   <= 1'b1;
      dp_s      <= 1'b1;
      snap_dp   <= 1'b1;
      shadow_dp <= '0;
      dp_out    <= '0;
    end else begin
      dp_meta <= dp_n;
      dp_s    <= dp_meta;
      if (load_snap) snap_dp <= dp_s;
      if (mask == 4'b1111) dp_out <= shadow_dp;
      else if (accept && glyph_dec[4]) shadow_dp[slot] <= ~snap_dp;
    end
  end

  assign same_snap = (an_s == snap_an) && (cat_s == snap_cat) && (dp_s == snap_dp);
`else
  logic dp_unused;
  assign dp_unused = dp_n;
  assign dp_out    = 4'b0000;
  assign same_snap = (an_s == snap_an) && (cat_s == snap_cat);
`endif

  assign glyph_dec = decode(~snap_cat);
  assign slot      = slot_of(snap_an);

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_snap = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (one_low(an_s)) begin
          state_nxt = SETTLE;
          load_snap = 1'b1;
        end
      end
      SETTLE: begin
        if (!same_snap) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (cnt >= SETTLE_LAST) begin
          state_nxt = HOLD;
          accept    = 1'b1;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        // Jump straight into the next digit so multiplexed digits keep full latency budget.
        if (an_s != snap_an) begin
          if (one_low(an_s)) begin
            state_nxt = SETTLE;
            load_snap = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      snap_an  <= '1;
      snap_cat <= '1;
    end else begin
      if (load_snap) begin
        cnt      <= SW'(1);
        snap_an  <= an_s;
        snap_cat <= cat_s;
      end else if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      mask   <= '0;
      value  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (mask == 4'b1111) begin
        value <= shadow;
        valid <= 1'b1;
        mask  <= '0;
      end else if (accept) begin
        if (glyph_dec[4]) begin
          shadow[{slot, 2'b00} +: 4] <= glyph_dec[3:0];
          mask[slot]                 <= 1'b1;
        end else begin
          err  <= 1'b1;
          mask <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n)                    to_cnt <= '0;
    else if (accept)               to_cnt <= '0;
    else if (to_cnt != TIMEOUT_MAX) to_cnt <= to_cnt + 1'b1;
  end

  assign stale = (to_cnt == TIMEOUT_MAX);

endmodule
